// File: rtl/mole_sprite_if.sv
// Pixel-timing, sprite-position, sprite-ROM and pixel-output signals of mole_sprite_reader.
// The slave modport is the reader's view; master is the video/ROM side.
interface mole_sprite_if;
    logic        pix_en;
    logic        line_start;
    logic        frame_start;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [9:0]  mole_x;
    logic [9:0]  mole_y;
    logic        mole_visible;
    logic [4:0]  rom_row;
    logic [63:0] rom_data;
    logic        pixel_valid;
    logic        pixel_on;

    modport slave (
        input  pix_en, line_start, frame_start, pix_x, pix_y,
        input  mole_x, mole_y, mole_visible, rom_data,
        output rom_row, pixel_valid, pixel_on
    );

    modport master (
        output pix_en, line_start, frame_start, pix_x, pix_y,
        output mole_x, mole_y, mole_visible, rom_data,
        input  rom_row, pixel_valid, pixel_on
    );
endinterface

// File: rtl/mole_sprite_reader.sv
// Fetches one sprite ROM row per scanline and serialises it MSB first at the sprite position.
// Define MOLE_SCALE2_EN for a 2x scaled sprite (128x64); default is 1:1 (64x32).
module mole_sprite_reader (
    input  logic           clk,
    input  logic           reset,
    mole_sprite_if.slave   bus
);
`ifdef MOLE_SCALE2_EN
    localparam int H = 64;
    localparam int W = 128;
    localparam bit SCALE2 = 1'b1;
`else
    localparam int H = 32;
    localparam int W = 64;
    localparam bit SCALE2 = 1'b0;
`endif
    localparam logic [7:0] W_CNT = 8'(W);

    typedef enum logic [1:0] {IDLE, LOAD, ARMED, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rom_row_q, rom_row_d;
    logic [63:0] shift_q, shift_d;
    logic [7:0]  col_q, col_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        pixel_on_q, pixel_on_d;
    logic [9:0]  mole_x_q, mole_x_d;
    logic [9:0]  mole_y_q, mole_y_d;
    logic        visible_q, visible_d;

    logic [10:0] dy;
    logic [4:0]  row_sel;
    logic        in_box;
    logic        emit;

    always_comb begin
        state_d       = state_q;
        rom_row_d     = rom_row_q;
        shift_d       = shift_q;
        col_d         = col_q;
        pixel_valid_d = pixel_valid_q;
        pixel_on_d    = pixel_on_q;
        mole_x_d      = mole_x_q;
        mole_y_d      = mole_y_q;
        visible_d     = visible_q;
        emit          = 1'b0;

        if (bus.frame_start) begin
            mole_x_d  = bus.mole_x;
            mole_y_d  = bus.mole_y;
            visible_d = bus.mole_visible;
        end

        // Uses the just-latched shadow values when frame_start and line_start coincide.
        dy     = {1'b0, bus.pix_y} - {1'b0, mole_y_d};
        in_box = visible_d && !dy[10] && (dy < 11'(H));
`ifdef MOLE_SCALE2_EN
        row_sel = dy[5:1];
`else
        row_sel = dy[4:0];
`endif

        if (bus.pix_en) begin
            pixel_valid_d = 1'b0;
            pixel_on_d    = 1'b0;
        end

        case (state_q)
            LOAD: begin
                shift_d = bus.rom_data;
                col_d   = 8'd0;
                state_d = ARMED;
            end
            ARMED: begin
                if (bus.pix_en && bus.pix_x == mole_x_q && mole_x_q < 10'd640)
                    emit = 1'b1;
            end
            SHIFT: begin
                if (bus.pix_en) begin
                    if (col_q == W_CNT)
                        state_d = IDLE;
                    else
                        emit = 1'b1;
                end
            end
            default: ;
        endcase

        if (emit) begin
            state_d       = SHIFT;
            pixel_valid_d = 1'b1;
            pixel_on_d    = shift_q[63];
            col_d         = col_q + 8'd1;
            // In 2x mode a bit advances only after its second pixel.
            if (!SCALE2 || col_q[0])
                shift_d = {shift_q[62:0], 1'b0};
        end

        if (bus.line_start) begin
            pixel_valid_d = 1'b0;
            pixel_on_d    = 1'b0;
            if (in_box) begin
                state_d   = LOAD;
                rom_row_d = row_sel;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rom_row_q     <= 5'd0;
            shift_q       <= 64'd0;
            col_q         <= 8'd0;
            pixel_valid_q <= 1'b0;
            pixel_on_q    <= 1'b0;
            mole_x_q      <= 10'd0;
            mole_y_q      <= 10'd0;
            visible_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_row_q     <= rom_row_d;
            shift_q       <= shift_d;
            col_q         <= col_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_on_q    <= pixel_on_d;
            mole_x_q      <= mole_x_d;
            mole_y_q      <= mole_y_d;
            visible_q     <= visible_d;
        end
    end

    assign bus.rom_row     = rom_row_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.pixel_on    = pixel_on_q;
endmodule
